aes_round_key_store: RTL and testbench

Word-serial key loader and round-key buffer between the key source and the AES datapath. It assembles a 128-bit cipher key from four 32-bit handshaked words and drives it into the pipelined key-expansion block. It then waits out that block's pipeline latency and latches all 11 round keys into a local store. The store serves any round key by index to an iterative cipher core.

---
 rtl/aes_round_key_store.sv | 125 ++++++++++++
 tb/tb_aes_round_key_store.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_key_store.sv
// Word-serial AES-128 key loader and 11-entry round-key store with registered read port.
// Optional ROUND_KEY_STORE_ZEROIZE_EN adds a synchronous zeroize input that wipes all key material.
module aes_round_key_store #(
  parameter int PIPE_LAT = 10
) (
  input  logic           clk,
  input  logic           rst,
`ifdef ROUND_KEY_STORE_ZEROIZE_EN
  input  logic           zeroize,
`endif
  input  logic           key_in_valid,
  output logic           key_in_ready,
  input  logic [31:0]    key_in,
  output logic [127:0]   key,
  output logic           key_active,
  input  logic [1407:0]  rk_flat,
  input  logic [3:0]     rk_idx,
  output logic [127:0]   rk_out,
  output logic           keys_ready
);

  // state   | meaning
  // IDLE    | no key loaded, waiting for word 0
  // LOAD    | collecting words 1..3
  // SETTLE  | expansion pipeline settling on new key
  // CAPTURE | latch all round keys into the store
  // READY   | store valid, a new word 0 starts a reload
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CAPTURE, READY} state_t;

  localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(PIPE_LAT - 1);

  state_t          state;
  logic [1:0]      word_cnt;
  logic [CW-1:0]   settle_cnt;
  logic [31:0]     slot [4];
  logic [127:0]    store [11];
  logic            accept;
  logic            zero_req;

  assign accept = key_in_valid & key_in_ready;

`ifdef ROUND_KEY_STORE_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      word_cnt     <= '0;
      settle_cnt   <= '0;
      key          <= '0;
      key_in_ready <= 1'b1;
      key_active   <= 1'b0;
      keys_ready   <= 1'b0;
      for (int i = 0; i < 4; i++) slot[i] <= '0;
      for (int i = 0; i < 11; i++) store[i] <= '0;
    end else if (zero_req) begin
      // wipe beats any word offered on the same edge
      state        <= IDLE;
      word_cnt     <= '0;
      settle_cnt   <= '0;
      key          <= '0;
      key_in_ready <= 1'b1;
      key_active   <= 1'b0;
      keys_ready   <= 1'b0;
      for (int i = 0; i < 4; i++) slot[i] <= '0;
      for (int i = 0; i < 11; i++) store[i] <= '0;
    end else begin
      case (state)
        IDLE, READY: begin
          if (accept) begin
            slot[0]    <= key_in;
            word_cnt   <= 2'd1;
            keys_ready <= 1'b0;
            state      <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            slot[word_cnt] <= key_in;
            word_cnt       <= word_cnt + 2'd1;
            if (word_cnt == 2'd3) begin
              // key only changes once the whole key is present
              key          <= {slot[0], slot[1], slot[2], key_in};
              settle_cnt   <= '0;
              key_in_ready <= 1'b0;
              key_active   <= 1'b1;
              state        <= SETTLE;
            end
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_cnt == SETTLE_LAST) begin
            key_active <= 1'b0;
            state      <= CAPTURE;
          end
        end
        CAPTURE: begin
          for (int i = 0; i < 11; i++) store[i] <= rk_flat[128*i +: 128];
          keys_ready   <= 1'b1;
          key_in_ready <= 1'b1;
          state        <= READY;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_out <= '0;
    end else if (zero_req) begin
      rk_out <= '0;
    end else if (rk_idx <= 4'd10) begin
      rk_out <= store[rk_idx];
    end else begin
      rk_out <= '0;
    end
  end

endmodule

// File: tb/tb_aes_round_key_store.sv
// Directed bench for aes_round_key_store: AES-128 expansion model drives rk_flat, a timeline
// model predicts every output each cycle, and FIPS-197 literals pin the model.
module tb_aes_round_key_store;
  localparam int PIPE_LAT = 10;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_in_valid = 1'b0;
  logic [31:0] key_in = '0;
  logic [3:0] rk_idx = '0;
  logic [1407:0] rk_flat = {44{32'hdeadbeef}};
  logic key_in_ready, key_active, keys_ready;
  logic [127:0] key, rk_out;
`ifdef ROUND_KEY_STORE_ZEROIZE_EN
  logic zeroize = 1'b0;
`endif

  int total = 0;
  int bad = 0;
  bit run_cmp = 0;

  always #5 clk = ~clk;

  aes_round_key_store #(.PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst(rst),
`ifdef ROUND_KEY_STORE_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .key_in_valid(key_in_valid), .key_in_ready(key_in_ready), .key_in(key_in),
    .key(key), .key_active(key_active), .rk_flat(rk_flat),
    .rk_idx(rk_idx), .rk_out(rk_out), .keys_ready(keys_ready)
  );

  // ---------------- AES-128 key expansion model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv, c;
    inv = 8'h00;
    if (a != 8'h00)
      for (int i = 1; i < 256; i++) begin
        c = 8'(i);
        if (gmul(a, c) == 8'h01) inv = c;
      end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1407:0] f;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) f[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return f;
  endfunction

  // Expansion block stand-in: round keys valid only after key has been stable PIPE_LAT cycles.
  initial begin
    logic [127:0] last_key;
    logic [1407:0] cache;
    int age;
    last_key = 'x; age = 0; cache = '0;
    forever begin
      @(negedge clk);
      if (key !== last_key) begin
        last_key = key;
        age = 0;
        cache = expand(key);
      end else if (age < 1000) age++;
      rk_flat = (age >= PIPE_LAT) ? cache : {44{32'hdeadbeef}};
    end
  end

  // ---------------- timeline model of the outputs ----------------
  int cyc, e_cyc, nw;
  bit pend, acc, zero;
  logic m_ready, m_active, m_kready;
  logic [127:0] m_key, m_rk;
  logic [1407:0] m_flat;
  logic [31:0] m_w [4];

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        cyc = 0; e_cyc = 0; nw = 0; pend = 0;
        m_ready = 1; m_active = 0; m_kready = 0;
        m_key = '0; m_rk = '0; m_flat = '0;
        for (int i = 0; i < 4; i++) m_w[i] = '0;
      end else begin
        cyc++;
        acc = key_in_valid && m_ready;
`ifdef ROUND_KEY_STORE_ZEROIZE_EN
        zero = zeroize;
`else
        zero = 0;
`endif
        m_rk = (rk_idx <= 4'd10) ? m_flat[128*rk_idx +: 128] : '0;
        if (pend && (cyc - e_cyc == PIPE_LAT + 1)) begin
          m_flat = expand(m_key);
          m_kready = 1;
          pend = 0;
        end
        if (zero) begin
          nw = 0; pend = 0; m_kready = 0;
          m_key = '0; m_rk = '0; m_flat = '0;
          for (int i = 0; i < 4; i++) m_w[i] = '0;
        end else if (acc) begin
          m_kready = 0;
          m_w[nw] = key_in;
          nw++;
          if (nw == 4) begin
            m_key = {m_w[0], m_w[1], m_w[2], m_w[3]};
            nw = 0;
            e_cyc = cyc;
            pend = 1;
          end
        end
        m_active = pend && (cyc - e_cyc <= PIPE_LAT - 1);
        m_ready = !pend;
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && run_cmp) begin
        chk("key_in_ready", key_in_ready, m_ready);
        chk("key_active", key_active, m_active);
        chk("keys_ready", keys_ready, m_kready);
        chk("key", key, m_key);
        chk("rk_out", rk_out, m_rk);
      end
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic send_word(input logic [31:0] w);
    bit ok;
    ok = 0;
    key_in_valid = 1'b1;
    key_in = w;
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = key_in_ready;
      @(negedge clk);
    end
    key_in_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout: word %h not taken within 200 cycles", w);
    end
  endtask

  task automatic send_key(input logic [127:0] k);
    for (int i = 0; i < 4; i++) send_word(k[127-32*i -: 32]);
  endtask

  task automatic wait_ready(output int n, output int act);
    n = 0; act = 0;
    while (!keys_ready && n < 100) begin
      if (key_active) act++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic rd(input logic [3:0] idx, input logic [127:0] exp, input string nm);
    rk_idx = idx;
    @(negedge clk);
    chk(nm, rk_out, exp);
  endtask

  initial begin
    int n, act;
    logic [1407:0] f;
    logic [127:0] k3;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_cmp = 1;
    chk("rst_key", key, 128'h0);
    chk("rst_key_in_ready", key_in_ready, 1);
    chk("rst_keys_ready", keys_ready, 0);

    f = expand(FIPS_KEY);
    chk("model_rk0", f[127:0], FIPS_KEY);
    chk("model_rk1", f[255:128], FIPS_RK1);
    chk("model_rk10", f[1407:1280], FIPS_RK10);
    f = expand(C1_KEY);
    chk("model_c1_rk10", f[1407:1280], C1_RK10);

    // FIPS-197 load, back to back
    send_key(FIPS_KEY);
    chk("fips_key", key, FIPS_KEY);
    wait_ready(n, act);
    chk("fips_ready_latency", n, PIPE_LAT + 1);
    chk("fips_active_len", act, PIPE_LAT);
    rd(4'd1, FIPS_RK1, "read_rk1");
    rd(4'd10, FIPS_RK10, "read_rk10");
    rd(4'd15, 128'h0, "read_idx15");
    rd(4'd0, FIPS_KEY, "read_rk0");

    // Reload from READY with a 7-cycle stall after word 1
    send_word(C1_KEY[127:96]);
    chk("reload_keys_ready", keys_ready, 0);
    rd(4'd1, FIPS_RK1, "old_store_rk1");
    send_word(C1_KEY[95:64]);
    repeat (7) @(negedge clk);
    chk("stall_key", key, FIPS_KEY);
    send_word(C1_KEY[63:32]);
    send_word(C1_KEY[31:0]);
    chk("c1_key", key, C1_KEY);
    wait_ready(n, act);
    chk("stall_ready_latency", n, PIPE_LAT + 1);
    rd(4'd10, C1_RK10, "c1_rk10");

    // New word offered during SETTLE must wait for READY
    k3 = 128'h3243f6a8885a308d313198a2e0370734;
    send_key(k3);
    send_word(32'h11111111);
    chk("early_word_waits", keys_ready, 0);
    send_word(32'h22222222);
    send_word(32'h33333333);
    send_word(32'h44444444);
    chk("k4_key", key, 128'h11111111222222223333333344444444);
    wait_ready(n, act);
    f = expand(128'h11111111222222223333333344444444);
    rd(4'd5, f[128*5 +: 128], "k4_rk5");

    // Asynchronous reset mid-SETTLE
    send_key(k3);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_key_active", key_active, 0);
    chk("arst_keys_ready", keys_ready, 0);
    chk("arst_key_in_ready", key_in_ready, 1);
    chk("arst_rk_out", rk_out, 128'h0);
    chk("arst_key", key, 128'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    rd(4'd1, 128'h0, "post_rst_store");

`ifdef ROUND_KEY_STORE_ZEROIZE_EN
    send_key(FIPS_KEY);
    wait_ready(n, act);
    rk_idx = 4'd1;
    zeroize = 1'b1;
    key_in_valid = 1'b1;
    key_in = 32'hcafef00d;
    @(negedge clk);
    zeroize = 1'b0;
    key_in_valid = 1'b0;
    chk("zero_key", key, 128'h0);
    chk("zero_rk_out", rk_out, 128'h0);
    chk("zero_keys_ready", keys_ready, 0);
    chk("zero_key_in_ready", key_in_ready, 1);
    rd(4'd10, 128'h0, "zero_store");
    send_key(C1_KEY);
    chk("zero_word_dropped", key, C1_KEY);
    wait_ready(n, act);
    rd(4'd10, C1_RK10, "zero_reload_rk10");
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
